// File: rtl/adc_ad7822_rectifier.sv
// Conversion sequencer for the rectifier board's two AD7822 ADCs (battery current and voltage).
// Starts both converters together, waits for both EOCs, reads both buses and optionally averages.
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | strobes high, waiting for a period tick
// CONVST  | convert-start pulse low for CONVST_W cycles
// WAIT    | waiting for both EOC done flags, bounded by TIMEOUT
// READ    | CS/RD low for RD_W cycles, buses captured on last
// ACCUM   | add captured bytes, publish average when complete
module adc_ad7822_rectifier #(
   parameter int SAMPLE_PERIOD = 500,
   parameter int CONVST_W      = 3,
   parameter int RD_W          = 4,
   parameter int TIMEOUT       = 100,
   parameter int AVG_LOG2      = 0
) (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_enable,
   input  logic       i_clear_err,
   input  logic       i_EOC_I,
   input  logic       i_EOC_V,
   input  logic [7:0] i_data_I,
   input  logic [7:0] i_data_V,
   output logic       o_CONVST,
   output logic       o_CS_n,
   output logic       o_RD_n,
   output logic [7:0] o_Ibat_ADC,
   output logic [7:0] o_Vbat_ADC,
   output logic       o_valid,
   output logic       o_timeout
);

   localparam int PER_W   = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int TMR_MAX = (TIMEOUT > CONVST_W) ? ((TIMEOUT > RD_W) ? TIMEOUT : RD_W)
                                                 : ((CONVST_W > RD_W) ? CONVST_W : RD_W);
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int ACC_W   = 8 + AVG_LOG2;
   localparam int CNT_W   = AVG_LOG2 + 1;

   localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);
   localparam logic [TMR_W-1:0] TMR_CNV  = TMR_W'(CONVST_W - 1);
   localparam logic [TMR_W-1:0] TMR_TO   = TMR_W'(TIMEOUT - 1);
   localparam logic [TMR_W-1:0] TMR_RD   = TMR_W'(RD_W - 1);
   localparam logic [CNT_W-1:0] AVG_N    = CNT_W'(1) << AVG_LOG2;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CONVST = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_READ   = 3'd3;
   localparam logic [2:0] S_ACCUM  = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [PER_W-1:0] per_q, per_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [2:0]       sync_i_q, sync_v_q;
   logic             done_i_q, done_i_d, done_v_q, done_v_d;
   logic [7:0]       cap_i_q, cap_i_d, cap_v_q, cap_v_d;
   logic [ACC_W-1:0] acc_i_q, acc_i_d, acc_v_q, acc_v_d;
   logic [ACC_W-1:0] sum_i, sum_v, avg_i, avg_v;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [7:0]       ibat_q, ibat_d, vbat_q, vbat_d;
   logic             valid_q, valid_d;
   logic             to_q, to_d, to_set;
   logic             convst_q, cs_q, rd_q;
   logic             tick, fall_i, fall_v;

   assign tick   = i_enable && (per_q == PER_LAST);
   // sync[1] is the synchronised level, sync[2] its previous value
   assign fall_i = sync_i_q[2] & ~sync_i_q[1];
   assign fall_v = sync_v_q[2] & ~sync_v_q[1];

   assign sum_i   = acc_i_q + ACC_W'(cap_i_q);
   assign sum_v   = acc_v_q + ACC_W'(cap_v_q);
   assign avg_i   = sum_i >> AVG_LOG2;
   assign avg_v   = sum_v >> AVG_LOG2;
   assign cnt_inc = cnt_q + 1'b1;

   always_comb begin
      per_d = per_q;
      if (!i_enable || per_q == PER_LAST) begin
         per_d = '0;
      end else begin
         per_d = per_q + 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      tmr_d    = tmr_q;
      done_i_d = done_i_q | fall_i;
      done_v_d = done_v_q | fall_v;
      cap_i_d  = cap_i_q;
      cap_v_d  = cap_v_q;
      acc_i_d  = acc_i_q;
      acc_v_d  = acc_v_q;
      cnt_d    = cnt_q;
      ibat_d   = ibat_q;
      vbat_d   = vbat_q;
      valid_d  = 1'b0;
      to_set   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (tick) begin
               state_d  = S_CONVST;
               tmr_d    = TMR_CNV;
               done_i_d = 1'b0;
               done_v_d = 1'b0;
            end
         end
         S_CONVST: begin
            if (tmr_q == '0) begin
               state_d = S_WAIT;
               tmr_d   = TMR_TO;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         S_WAIT: begin
            if (done_i_d && done_v_d) begin
               state_d = S_READ;
               tmr_d   = TMR_RD;
            end else if (tmr_q == '0) begin
               state_d = S_IDLE;
               to_set  = 1'b1;
               acc_i_d = '0;
               acc_v_d = '0;
               cnt_d   = '0;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         S_READ: begin
            if (tmr_q == '0) begin
               state_d = S_ACCUM;
               cap_i_d = i_data_I;
               cap_v_d = i_data_V;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         S_ACCUM: begin
            state_d = S_IDLE;
            if (cnt_inc == AVG_N) begin
               ibat_d  = avg_i[7:0];
               vbat_d  = avg_v[7:0];
               acc_i_d = '0;
               acc_v_d = '0;
               cnt_d   = '0;
               valid_d = 1'b1;
            end else begin
               acc_i_d = sum_i;
               acc_v_d = sum_v;
               cnt_d   = cnt_inc;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // a timeout raised in the same cycle as a clear request wins
      to_d = to_set | (to_q & ~i_clear_err);
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q  <= S_IDLE;
         per_q    <= '0;
         tmr_q    <= '0;
         sync_i_q <= 3'b111;
         sync_v_q <= 3'b111;
         done_i_q <= 1'b0;
         done_v_q <= 1'b0;
         cap_i_q  <= '0;
         cap_v_q  <= '0;
         acc_i_q  <= '0;
         acc_v_q  <= '0;
         cnt_q    <= '0;
         ibat_q   <= '0;
         vbat_q   <= '0;
         valid_q  <= 1'b0;
         to_q     <= 1'b0;
         convst_q <= 1'b1;
         cs_q     <= 1'b1;
         rd_q     <= 1'b1;
      end else begin
         state_q  <= state_d;
         per_q    <= per_d;
         tmr_q    <= tmr_d;
         sync_i_q <= {sync_i_q[1:0], i_EOC_I};
         sync_v_q <= {sync_v_q[1:0], i_EOC_V};
         done_i_q <= done_i_d;
         done_v_q <= done_v_d;
         cap_i_q  <= cap_i_d;
         cap_v_q  <= cap_v_d;
         acc_i_q  <= acc_i_d;
         acc_v_q  <= acc_v_d;
         cnt_q    <= cnt_d;
         ibat_q   <= ibat_d;
         vbat_q   <= vbat_d;
         valid_q  <= valid_d;
         to_q     <= to_d;
         convst_q <= (state_d != S_CONVST);
         cs_q     <= (state_d != S_READ);
         rd_q     <= (state_d != S_READ);
      end
   end

   assign o_CONVST   = convst_q;
   assign o_CS_n     = cs_q;
   assign o_RD_n     = rd_q;
   assign o_Ibat_ADC = ibat_q;
   assign o_Vbat_ADC = vbat_q;
   assign o_valid    = valid_q;
   assign o_timeout  = to_q;

endmodule

// File: tb/tb_adc_ad7822_rectifier.sv
// Bench for adc_ad7822_rectifier: behavioural AD7822 pair, conversion vector table
// on a default instance, plus averaging, reset and enable sequences.
module tb_adc_ad7822_rectifier;

   localparam int SP = 500;
   localparam int CW = 3;
   localparam int RW = 4;
   localparam int TO = 100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       clr = 1'b0;
   logic       eoc_i = 1'b1;
   logic       eoc_v = 1'b1;
   logic [7:0] d_i = 8'h00;
   logic [7:0] d_v = 8'h00;

   logic       convst0, cs0, rd0, val0, to0;
   logic [7:0] ib0, vb0;
   logic       convst1, cs1, rd1, val1, to1;
   logic [7:0] ib1, vb1;

   adc_ad7822_rectifier u0 (
      .i_clock(clk), .i_reset(rst), .i_enable(en), .i_clear_err(clr),
      .i_EOC_I(eoc_i), .i_EOC_V(eoc_v), .i_data_I(d_i), .i_data_V(d_v),
      .o_CONVST(convst0), .o_CS_n(cs0), .o_RD_n(rd0),
      .o_Ibat_ADC(ib0), .o_Vbat_ADC(vb0), .o_valid(val0), .o_timeout(to0)
   );

   adc_ad7822_rectifier #(.AVG_LOG2(2)) u1 (
      .i_clock(clk), .i_reset(rst), .i_enable(en), .i_clear_err(clr),
      .i_EOC_I(eoc_i), .i_EOC_V(eoc_v), .i_data_I(d_i), .i_data_V(d_v),
      .o_CONVST(convst1), .o_CS_n(cs1), .o_RD_n(rd1),
      .o_Ibat_ADC(ib1), .o_Vbat_ADC(vb1), .o_valid(val1), .o_timeout(to1)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // ADC model and strobe monitor, sampled 1 time unit after each rising edge
   int dly_i = 21, dly_v = 21, ci = -1, cv = -1;
   int cw = 0, last_cw = 0, rw = 0, last_rw = 0;
   int cfall = 0, crise_cyc = 0, rd_start = 0, eoc_i_cyc = 0, eoc_v_cyc = 0;
   int v0_cnt = 0, v0_cyc = 0, v1_cnt = 0, to_cyc = 0;
   logic p_conv = 1'b1, p_rd = 1'b1, p_to = 1'b0;

   initial forever begin
      @(posedge clk);
      #1;
      if (!convst0 && p_conv) begin
         cfall++;
         eoc_i = 1'b1; eoc_v = 1'b1; ci = -1; cv = -1;
      end
      if (!convst0) cw++;
      if (convst0 && !p_conv) begin
         last_cw = cw; cw = 0; crise_cyc = cyc;
         ci = dly_i; cv = dly_v;
      end else begin
         if (ci > 0) begin
            ci--;
            if (ci == 0) begin eoc_i = 1'b0; eoc_i_cyc = cyc; ci = -1; end
         end
         if (cv > 0) begin
            cv--;
            if (cv == 0) begin eoc_v = 1'b0; eoc_v_cyc = cyc; cv = -1; end
         end
      end
      if (!rd0 && p_rd) begin
         rd_start = cyc;
         eoc_i = 1'b1; eoc_v = 1'b1;
      end
      if (!rd0) rw++;
      if (rd0 && !p_rd) begin last_rw = rw; rw = 0; end
      if (cs0 != rd0) begin
         n_err++;
         $display("FAIL cs_rd_match: cs=%0d rd=%0d at cycle %0d", cs0, rd0, cyc);
      end
      if (val0) begin v0_cnt++; v0_cyc = cyc; end
      if (val1) v1_cnt++;
      if (to0 && !p_to) to_cyc = cyc;
      p_conv = convst0; p_rd = rd0; p_to = to0;
   end

   task automatic cycles(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic wait_convst(input string nm, input int budget);
      int b = cfall;
      int k = 0;
      while (cfall == b && k < budget) begin cycles(1); k++; end
      if (cfall == b) chk({nm, "_convst_wait_expired"}, 0, 1);
   endtask

   task automatic wait_valid(input string nm, input int budget);
      int b = v0_cnt;
      int k = 0;
      while (v0_cnt == b && k < budget) begin cycles(1); k++; end
      if (v0_cnt == b) chk({nm, "_valid_wait_expired"}, 0, 1);
   endtask

   task automatic wait_rd_low(input string nm, input int budget);
      int k = 0;
      while (rd0 && k < budget) begin cycles(1); k++; end
      if (rd0) chk({nm, "_rd_wait_expired"}, 0, 1);
   endtask

   typedef struct {
      logic [7:0] di;
      logic [7:0] dv;
      int         dli;
      int         dlv;
      logic [7:0] ei;
      logic [7:0] ev;
      int         evalid;
      int         eto;
   } vec_t;

   vec_t vt[5];

   initial begin
      int bv, b, lat, last_eoc, rel, b1;
      int avg_i[4];

      vt[0] = '{8'h5A, 8'hC3, 21, 21, 8'h5A, 8'hC3, 1, 0};
      vt[1] = '{8'h00, 8'hFF, 21, 51, 8'h00, 8'hFF, 1, 0};
      vt[2] = '{8'h33, 8'h44, 21, -1, 8'h00, 8'hFF, 0, 1};
      vt[3] = '{8'hA5, 8'h5A, 40, 10, 8'hA5, 8'h5A, 1, 1};
      vt[4] = '{8'hFF, 8'h00,  1,  1, 8'hFF, 8'h00, 1, 1};
      avg_i = '{10, 11, 12, 14};

      rst = 1'b1;
      cycles(3);
      chk("rst_convst", convst0, 1);
      chk("rst_cs", cs0, 1);
      chk("rst_rd", rd0, 1);
      chk("rst_ibat", ib0, 0);
      chk("rst_vbat", vb0, 0);
      chk("rst_valid", val0, 0);
      chk("rst_timeout", to0, 0);
      rst = 1'b0;
      en = 1'b1;

      for (int i = 0; i < 5; i++) begin
         d_i = vt[i].di; d_v = vt[i].dv;
         dly_i = vt[i].dli; dly_v = vt[i].dlv;
         bv = v0_cnt;
         wait_convst($sformatf("v%0d", i), 700);
         cycles(200);
         chk($sformatf("v%0d_valid_pulses", i), v0_cnt - bv, vt[i].evalid);
         chk($sformatf("v%0d_ibat", i), ib0, vt[i].ei);
         chk($sformatf("v%0d_vbat", i), vb0, vt[i].ev);
         chk($sformatf("v%0d_timeout", i), to0, vt[i].eto);
         chk($sformatf("v%0d_convst_width", i), last_cw, CW);
         if (vt[i].evalid != 0) begin
            last_eoc = (eoc_i_cyc > eoc_v_cyc) ? eoc_i_cyc : eoc_v_cyc;
            chk($sformatf("v%0d_rd_width", i), last_rw, RW);
            chk($sformatf("v%0d_eoc_to_read", i), rd_start - last_eoc, 3);
            chk($sformatf("v%0d_read_to_valid", i), v0_cyc - rd_start, RW + 1);
         end else begin
            chk($sformatf("v%0d_timeout_after_wait", i), to_cyc - crise_cyc, TO);
         end
      end

      clr = 1'b1;
      cycles(1);
      clr = 1'b0;
      chk("clear_err", to0, 0);

      // reset in the middle of a read
      d_i = 8'h12; d_v = 8'h34; dly_i = 21; dly_v = 21;
      wait_rd_low("rst", 700);
      cycles(1);
      rst = 1'b1;
      #1;
      chk("async_rst_convst", convst0, 1);
      chk("async_rst_cs", cs0, 1);
      chk("async_rst_rd", rd0, 1);
      chk("async_rst_ibat", ib0, 0);
      chk("async_rst_vbat", vb0, 0);
      chk("async_rst_valid", val0, 0);
      cycles(2);
      rst = 1'b0;
      rel = cyc;
      wait_valid("rst", 800);
      lat = v0_cyc - rel;
      chk("rst_first_valid_cycle", lat, SP + CW + 21 + 3 + RW + 1);
      chk("rst_first_ibat", ib0, 8'h12);
      chk("rst_first_vbat", vb0, 8'h34);

      // averaging over four conversions
      rst = 1'b1;
      cycles(2);
      rst = 1'b0;
      b1 = v1_cnt;
      for (int s = 0; s < 4; s++) begin
         d_i = 8'(avg_i[s]); d_v = 8'hFF;
         wait_valid($sformatf("avg%0d", s), 700);
         if (s == 2) chk("avg_no_valid_before_4th", v1_cnt - b1, 0);
      end
      cycles(2);
      chk("avg_valid_pulses", v1_cnt - b1, 1);
      chk("avg_ibat", ib1, 11);
      chk("avg_vbat", vb1, 255);

      // enable gating
      rst = 1'b1;
      cycles(2);
      en = 1'b0;
      rst = 1'b0;
      b = cfall;
      cycles(2000);
      chk("enable_off_no_convst", cfall - b, 0);
      d_i = 8'h3C; d_v = 8'h96;
      en = 1'b1;
      wait_convst("en_mid", 700);
      cycles(CW + 5);
      en = 1'b0;
      bv = v0_cnt;
      wait_valid("en_mid", 200);
      chk("enable_drop_valid", v0_cnt - bv, 1);
      chk("enable_drop_ibat", ib0, 8'h3C);
      chk("enable_drop_vbat", vb0, 8'h96);
      b = cfall;
      cycles(1200);
      chk("enable_drop_no_new_convst", cfall - b, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
